// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel/line counters, display enable and lock
// status from active-low hsync/vsync of a 640x480@60 timing source running
// on the same pixel clock.
// Optional: define VGA_DEC_ERRCNT_EN to add an 8-bit saturating err_count
// output that counts sync_err pulses.
module vga_sync_decoder #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_TOTAL       = 800,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_TOTAL       = 521,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
`ifdef VGA_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [9:0]  H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0]  H_SYNC_COL  = 10'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SYNC_LINE = 10'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0] LINE_OK     = 11'(H_TOTAL);
    localparam logic [10:0] LINE_MAX    = 11'(2 * H_TOTAL);
    localparam logic [9:0]  FRAME_OK    = 10'(V_TOTAL);
    localparam logic [3:0]  LOCK_CNT    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state, state_n;
    logic        hs_d, vs_d;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic        frame_bad;
    logic [3:0]  good_cnt, good_cnt_n;
    logic        hfall, vfall, hwrap, line_bad, frame_fail, err_n;
    logic [9:0]  hcount_n, vcount_n;

    // Sync edge detection, next counter values and period checks
    always_comb begin
        hfall = hs_d & ~hsync_in;
        vfall = vs_d & ~vsync_in;
        hwrap = ~hfall & (hcount == H_LAST);

        if (hfall)      hcount_n = H_SYNC_COL;
        else if (hwrap) hcount_n = '0;
        else            hcount_n = hcount + 10'd1;

        // vfall wins over a line wrap in the same cycle
        if (vfall)      vcount_n = V_SYNC_LINE;
        else if (hwrap) vcount_n = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        else            vcount_n = vcount;

        // A line is bad on a wrong-length hfall, or once when hsync goes
        // missing for two full line periods
        if (hfall) line_bad = ((line_len + 11'd1) != LINE_OK);
        else       line_bad = ((line_len + 11'd1) == LINE_MAX);

        // A bad line flagged on the vfall cycle still belongs to this frame
        frame_fail = (frame_lines != FRAME_OK) | frame_bad | line_bad;
    end

    // Lock state machine: next state, good-frame count and error pulse
    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        err_n      = 1'b0;
        case (state)
            SEARCH: begin
                if (vfall) begin
                    state_n    = ACQUIRE;
                    good_cnt_n = '0;
                end
            end
            ACQUIRE: begin
                if (vfall) begin
                    if (frame_fail) begin
                        good_cnt_n = '0;
                    end else begin
                        good_cnt_n = good_cnt + 4'd1;
                        if ((good_cnt + 4'd1) == LOCK_CNT) state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (line_bad | (vfall & frame_fail)) begin
                    state_n    = SEARCH;
                    good_cnt_n = '0;
                    err_n      = 1'b1;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    // State, counters and registered outputs; en freezes everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            hcount      <= '0;
            vcount      <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_bad   <= 1'b0;
            state       <= SEARCH;
            good_cnt    <= '0;
            locked      <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else if (en) begin
            hs_d   <= hsync_in;
            vs_d   <= vsync_in;
            hcount <= hcount_n;
            vcount <= vcount_n;

            if (hfall)                   line_len <= '0;
            else if (line_len != LINE_MAX) line_len <= line_len + 11'd1;

            // A coincident hfall opens the new frame's line count
            if (vfall) begin
                frame_lines <= {9'd0, hfall};
                frame_bad   <= 1'b0;
            end else begin
                if (hfall && (frame_lines != '1)) frame_lines <= frame_lines + 10'd1;
                frame_bad <= frame_bad | line_bad;
            end

            state    <= state_n;
            good_cnt <= good_cnt_n;

            // locked trails state by one cycle; de/frame_start use the same
            // term so they stay consistent with locked and the counters
            locked      <= (state == LOCKED);
            de          <= (state == LOCKED) && (hcount_n < H_VIS) && (vcount_n < V_VIS);
            frame_start <= (state == LOCKED) && (hcount_n == '0) && (vcount_n == '0);
            sync_err    <= err_n;
        end
    end

`ifdef VGA_DEC_ERRCNT_EN
    // Saturating count of sync_err pulses, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)                                err_count <= '0;
        else if (en && err_n && (err_count != '1)) err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using reduced timing (32x20) so that many
// frames fit in a short run. Randomized and directed stimulus is compared
// every cycle against an event/timestamp based reference model.
module tb_vga_sync_decoder;

    localparam int HV = 16, HFP = 4, HT = 32, HSW = 4;
    localparam int VV = 12, VFP = 2, VT = 20, VSW = 2;
    localparam int LF = 2;
    localparam int HS0 = HV + HFP;
    localparam int VS0 = VV + VFP;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [9:0] hcount, vcount;
    logic       de, locked, frame_start, sync_err;
`ifdef VGA_DEC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int n_cmp = 0, n_bad = 0;

    // timing generator state
    int gx = 0, gy = 0, g_lt = HT, g_ft = VT;
    bit g_hold = 0, g_free = 0;
    int s_gx, s_gy;
    bit s_vf;

    // reference model state
    int m_hsd, m_vsd, m_h, m_v, m_t, m_th, m_fl, m_fb, m_mode, m_good;
    int m_de, m_lk, m_fs, m_er, m_ec;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT_PORCH(HFP), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hcount(hcount), .vcount(vcount), .de(de), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err)
`ifdef VGA_DEC_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] outs();
        return {hcount, vcount, de, locked, frame_start, sync_err};
    endfunction

    function automatic logic [23:0] mexp();
        return {m_h[9:0], m_v[9:0], m_de[0], m_lk[0], m_fs[0], m_er[0]};
    endfunction

    // Reference model: line length from hfall timestamps, frame quality from
    // hfall counts between vfalls, lock from a count of good frames.
    task automatic model_step();
        int hf, vf, bad, ffail, nh, nv, nm, ng, er;
        if (!rst_n) begin
            m_hsd = 1; m_vsd = 1; m_h = 0; m_v = 0; m_t = 0; m_th = 0;
            m_fl = 0; m_fb = 0; m_mode = 0; m_good = 0;
            m_de = 0; m_lk = 0; m_fs = 0; m_er = 0; m_ec = 0;
            return;
        end
        if (!en) return;
        m_t++;
        hf = (m_hsd == 1 && hsync_in == 1'b0) ? 1 : 0;
        vf = (m_vsd == 1 && vsync_in == 1'b0) ? 1 : 0;
        m_hsd = hsync_in ? 1 : 0;
        m_vsd = vsync_in ? 1 : 0;
        if (hf) bad = (m_t - m_th != HT) ? 1 : 0;
        else    bad = (m_t - m_th == 2 * HT) ? 1 : 0;
        if (hf) m_th = m_t;
        nh = hf ? HS0 : (m_h + 1) % HT;
        nv = vf ? VS0 : ((!hf && nh == 0) ? (m_v + 1) % VT : m_v);
        ffail = (vf && (m_fl != VT || m_fb || bad)) ? 1 : 0;
        if (vf) begin
            m_fl = hf; m_fb = 0;
        end else begin
            if (hf && m_fl < 1023) m_fl++;
            m_fb = m_fb | bad;
        end
        er = 0; nm = m_mode; ng = m_good;
        case (m_mode)
            0: if (vf) begin nm = 1; ng = 0; end
            1: if (vf) begin
                   if (ffail) ng = 0;
                   else begin ng++; if (ng == LF) nm = 2; end
               end
            default: if (bad || ffail) begin nm = 0; ng = 0; er = 1; end
        endcase
        m_lk = (m_mode == 2) ? 1 : 0;
        m_de = (m_lk && nh < HV && nv < VV) ? 1 : 0;
        m_fs = (m_lk && nh == 0 && nv == 0) ? 1 : 0;
        m_er = er;
        if (er && m_ec < 255) m_ec++;
        m_h = nh; m_v = nv; m_mode = nm; m_good = ng;
    endtask

    // One pixel clock: present generator sample, clock it, update model,
    // then advance the generator (only when the decoder samples, unless free)
    task automatic cyc();
        hsync_in = g_hold ? 1'b1 : !(gx >= HS0 && gx < HS0 + HSW);
        vsync_in = !(gy >= VS0 && gy < VS0 + VSW);
        s_gx = gx; s_gy = gy; s_vf = (gx == 0 && gy == VS0);
        @(posedge clk);
        model_step();
        #1;
        if (en || g_free) begin
            if (gx >= g_lt - 1) begin
                gx = 0; g_lt = HT;
                if (gy >= g_ft - 1) begin gy = 0; g_ft = VT; end
                else gy++;
            end else gx++;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; gx = 0; gy = 0;
        repeat (2) cyc();
        n_cmp++;
        if (outs() !== 24'h0) begin
            n_bad++; $display("FAIL reset_outputs got=%h want=000000", outs());
        end
        n_cmp++;
        if (outs() !== mexp()) begin
            n_bad++; $display("FAIL reset_model got=%h want=%h", outs(), mexp());
        end
    endtask

    task automatic test_lock();
        int nvf = 0, after = -1, win = -1, de_n = 0, fs_n = 0;
        rst_n = 1; en = 1;
        for (int i = 0; i < 6 * HT * VT; i++) begin
            cyc();
            n_cmp++;
            if (outs() !== mexp()) begin
                n_bad++; $display("FAIL lock_model t=%0t got=%h want=%h", $time, outs(), mexp());
            end
            if (s_vf) begin
                nvf++;
                if (nvf == 3) begin
                    n_cmp++;
                    if (locked !== 1'b0) begin
                        n_bad++; $display("FAIL lock_early got=%b want=0", locked);
                    end
                    after = i + 1;
                end
            end
            if (i == after) begin
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_bad++; $display("FAIL lock_rise got=%b want=1", locked);
                end
            end
            if (m_lk == 1) begin
                n_cmp++;
                if (hcount !== 10'(s_gx) || vcount !== 10'(s_gy)) begin
                    n_bad++; $display("FAIL lock_pos got=%0d,%0d want=%0d,%0d", hcount, vcount, s_gx, s_gy);
                end
            end
            if (win < 0 && m_lk == 1 && s_gx == 0 && s_gy == 0) win = 0;
            if (win >= 0 && win < 2 * HT * VT) begin
                de_n += int'(de); fs_n += int'(frame_start); win++;
            end
        end
        n_cmp++;
        if (win != 2 * HT * VT) begin n_bad++; $display("FAIL lock_window got=%0d want=%0d", win, 2 * HT * VT); end
        n_cmp++;
        if (de_n != 2 * HV * VV) begin n_bad++; $display("FAIL de_count got=%0d want=%0d", de_n, 2 * HV * VV); end
        n_cmp++;
        if (fs_n != 2) begin n_bad++; $display("FAIL fs_count got=%0d want=2", fs_n); end
    endtask

    task automatic test_stretch();
        int errs = 0, err_at = -1, nvf = 0, after = -1;
        bit found = 0;
        for (int k = 0; k < 2 * HT; k++) begin
            cyc();
            if (s_gx == 5) begin found = 1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL stretch_align got=0 want=1"); end
        g_lt = HT + 1;
        for (int i = 0; i < 5 * HT * VT; i++) begin
            cyc();
            n_cmp++;
            if (outs() !== mexp()) begin
                n_bad++; $display("FAIL stretch_model t=%0t got=%h want=%h", $time, outs(), mexp());
            end
            if (sync_err === 1'b1) begin
                errs++;
                if (errs == 1) begin
                    err_at = i;
                    n_cmp++;
                    if (s_gx != HS0 || locked !== 1'b1) begin
                        n_bad++; $display("FAIL err_place got=col%0d,lk%b want=col%0d,lk1", s_gx, locked, HS0);
                    end
                end
            end
            if (err_at >= 0 && i == err_at + 1) begin
                n_cmp++;
                if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_fall got=%b want=0", locked); end
            end
            if (err_at >= 0 && s_vf) begin
                nvf++;
                if (nvf == 3) after = i + 1;
            end
            if (i == after) begin
                n_cmp++;
                if (locked !== 1'b1) begin n_bad++; $display("FAIL relock got=%b want=1", locked); end
            end
        end
        n_cmp++;
        if (errs != 1) begin n_bad++; $display("FAIL stretch_errs got=%0d want=1", errs); end
        n_cmp++;
        if (after < 0) begin n_bad++; $display("FAIL relock_vfalls got=%0d want=3", nvf); end
    endtask

    task automatic test_timeout();
        bit found = 0;
        for (int k = 0; k < 2 * HT; k++) begin
            cyc();
            if (s_gx == HS0) begin found = 1; break; end
        end
        n_cmp++;
        if (!found || locked !== 1'b1) begin
            n_bad++; $display("FAIL timeout_start got=%b,%b want=1,1", found, locked);
        end
        g_hold = 1;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            n_cmp++;
            if (outs() !== mexp()) begin
                n_bad++; $display("FAIL timeout_model t=%0t got=%h want=%h", $time, outs(), mexp());
            end
            n_cmp++;
            if (sync_err !== 1'(k == 2 * HT)) begin
                n_bad++; $display("FAIL timeout_err k=%0d got=%b want=%b", k, sync_err, k == 2 * HT);
            end
        end
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL timeout_unlock got=%b want=0", locked); end
        g_hold = 0;
    endtask

    task automatic test_short_frame();
        int nvf = 0, after3 = -1, after4 = -1;
        rst_n = 0; en = 0; gx = 0; gy = 0; g_lt = HT; g_ft = VT;
        cyc();
        rst_n = 1; en = 1;
        for (int i = 0; i < 6 * HT * VT; i++) begin
            cyc();
            n_cmp++;
            if (outs() !== mexp()) begin
                n_bad++; $display("FAIL short_model t=%0t got=%h want=%h", $time, outs(), mexp());
            end
            if (nvf < 4) begin
                n_cmp++;
                if (sync_err !== 1'b0) begin n_bad++; $display("FAIL acq_silent got=%b want=0", sync_err); end
            end
            if (s_vf) begin
                nvf++;
                if (nvf == 1) g_ft = VT - 1;
                if (nvf == 3) after3 = i + 1;
                if (nvf == 4) after4 = i + 1;
            end
            if (i == after3) begin
                n_cmp++;
                if (locked !== 1'b0) begin n_bad++; $display("FAIL short_nolock got=%b want=0", locked); end
            end
            if (i == after4) begin
                n_cmp++;
                if (locked !== 1'b1) begin n_bad++; $display("FAIL short_relock got=%b want=1", locked); end
            end
        end
        n_cmp++;
        if (after4 < 0) begin n_bad++; $display("FAIL short_vfalls got=%0d want=4", nvf); end
    endtask

    task automatic test_reset_en();
        int h0, v0;
        bit found = 0;
        for (int k = 0; k < 2 * HT; k++) begin
            cyc();
            if (s_gx == 10) begin found = 1; break; end
        end
        n_cmp++;
        if (!found || locked !== 1'b1) begin
            n_bad++; $display("FAIL midreset_start got=%b,%b want=1,1", found, locked);
        end
        rst_n = 0; en = 0;
        cyc();
        n_cmp++;
        if (outs() !== 24'h0) begin n_bad++; $display("FAIL midreset_out got=%h want=000000", outs()); end
        rst_n = 1; en = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n_cmp++;
            if (outs() !== mexp()) begin
                n_bad++; $display("FAIL postreset_model got=%h want=%h", outs(), mexp());
            end
        end
        h0 = m_h; v0 = m_v;
        en = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            n_cmp++;
            if (hcount !== 10'(h0) || vcount !== 10'(v0)) begin
                n_bad++; $display("FAIL freeze got=%0d,%0d want=%0d,%0d", hcount, vcount, h0, v0);
            end
        end
        en = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_cmp++;
            if (outs() !== mexp()) begin
                n_bad++; $display("FAIL resume_model got=%h want=%h", outs(), mexp());
            end
        end
    endtask

    task automatic test_random();
        int hold_left = 0;
        rst_n = 0; en = 0; gx = 0; gy = 0; g_lt = HT; g_ft = VT; g_hold = 0; g_free = 0;
        cyc();
        for (int i = 0; i < 5000; i++) begin
            rst_n  = ($urandom_range(2999) != 0);
            en     = ($urandom_range(99) < 96);
            g_free = ($urandom_range(3) == 0);
            if ($urandom_range(299) == 0) g_lt = HT - 2 + int'($urandom_range(4));
            if ($urandom_range(1999) == 0) g_ft = VT - 1;
            if (hold_left == 0 && $urandom_range(999) == 0) begin
                g_hold = 1; hold_left = 10 + int'($urandom_range(90));
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) g_hold = 0;
            end
            cyc();
            n_cmp++;
            if (outs() !== mexp()) begin
                n_bad++; $display("FAIL random_model t=%0t got=%h want=%h", $time, outs(), mexp());
            end
`ifdef VGA_DEC_ERRCNT_EN
            n_cmp++;
            if (err_count !== 8'(m_ec)) begin
                n_bad++; $display("FAIL random_errcnt got=%0d want=%0d", err_count, m_ec);
            end
`endif
        end
        rst_n = 1; en = 1; g_hold = 0; g_free = 0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stretch();
        test_timeout();
        test_short_frame();
        test_reset_en();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
